// File: rtl/vsync_frame_decoder_if.sv
// Bundle between a VSYNC source and vsync_frame_decoder.
// Optional macro VSYNC_DEC_ERRCNT_EN adds the err_count signal.
//
// Signalling: there is no back-pressure. frame_start and err are strobes,
// valid only in the single clk cycle they are high; the sink must sample
// them every cycle. row is meaningful only while de is high. state is a
// debug view of the decoder FSM.
interface vsync_frame_decoder_if;
  logic       vsync_in;
  logic [6:0] row;
  logic       de;
  logic       frame_start;
  logic       locked;
  logic       err;
  logic [2:0] state;
`ifdef VSYNC_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  modport master (
    output vsync_in,
    input  row, de, frame_start, locked, err, state
`ifdef VSYNC_DEC_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  vsync_in,
    output row, de, frame_start, locked, err, state
`ifdef VSYNC_DEC_ERRCNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/vsync_frame_decoder.sv
// Receive-side VSYNC decoder: measures pulse width and porch timing of an
// active-low VSYNC, regenerates row index / display-valid, reports lock and
// timing errors. Optional macro VSYNC_DEC_ERRCNT_EN adds a saturating
// 8-bit error counter (err_count).
module vsync_frame_decoder #(
  parameter int PULSE_CYC = 64000,
  parameter int BP_CYC    = 92800,
  parameter int ROW_CYC   = 16000,
  parameter int ROWS      = 96,
  parameter int FP_CYC    = 32000,
  parameter int TOL_CYC   = 16,
  parameter int LOCK_FRM  = 2
) (
  input  logic clk,
  input  logic reset,
  vsync_frame_decoder_if.slave bus
);

  localparam int CNT_W = 17;
  localparam int GW    = (LOCK_FRM < 2) ? 1 : $clog2(LOCK_FRM + 1);

  // Pulse width is cnt+1 at the rise, so the width bounds are shifted by one.
  localparam logic [CNT_W-1:0] W_MIN_CNT = CNT_W'(PULSE_CYC - TOL_CYC - 1);
  localparam logic [CNT_W-1:0] W_MAX_CNT = CNT_W'(PULSE_CYC + TOL_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_TO  = CNT_W'(PULSE_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(BP_CYC - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROW_CYC - 1);
  localparam logic [CNT_W-1:0] FP_MIN    = CNT_W'(FP_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] FP_MAX    = CNT_W'(FP_CYC + TOL_CYC);
  localparam logic [6:0]       ROW_FINAL = 7'(ROWS - 1);
  localparam logic [GW-1:0]    GOOD_MAX  = GW'(LOCK_FRM);

  typedef enum logic [2:0] {
    ST_SEARCH     = 3'd0,
    ST_PULSE      = 3'd1,
    ST_BACKPORCH  = 3'd2,
    ST_DISPLAY    = 3'd3,
    ST_FRONTPORCH = 3'd4
  } state_t;

  logic             sync1_q, sync2_q, sync3_q;
  logic             fall, rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       row_q, row_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [GW-1:0]    good_q, good_d;
  logic             good_frame;

  // Synchronize the pin; sync3_q holds the previous synchronized value for edge detect.
  // Idle level is high so reset does not fabricate a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= bus.vsync_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fall = sync3_q & ~sync2_q;
  assign rise = ~sync3_q & sync2_q;

  // Next-state, counter, row and lock computation; an edge always wins over a timeout or advance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    row_d      = row_q;
    fs_d       = 1'b0;
    err_d      = 1'b0;
    good_d     = good_q;
    good_frame = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        cnt_d = '0;
        if (fall) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (rise) begin
          if (cnt_q >= W_MIN_CNT && cnt_q <= W_MAX_CNT) begin
            state_d = ST_BACKPORCH;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end
        end else if (cnt_q > PULSE_TO) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      ST_BACKPORCH: begin
        if (fall) begin
          err_d   = 1'b1;
          state_d = ST_PULSE;
        end else if (cnt_q == BP_LAST) begin
          fs_d    = 1'b1;
          state_d = ST_DISPLAY;
        end
      end
      ST_DISPLAY: begin
        if (fall) begin
          err_d   = 1'b1;
          state_d = ST_PULSE;
        end else if (cnt_q == ROW_LAST) begin
          cnt_d = '0;
          if (row_q == ROW_FINAL) state_d = ST_FRONTPORCH;
          else                    row_d   = row_q + 7'd1;
        end
      end
      ST_FRONTPORCH: begin
        if (fall) begin
          state_d = ST_PULSE;
          if (cnt_q >= FP_MIN && cnt_q <= FP_MAX) good_frame = 1'b1;
          else                                    err_d      = 1'b1;
        end else if (cnt_q > FP_MAX) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SEARCH;
      end
    endcase

    if (state_d != state_q)     cnt_d = '0;
    if (state_d != ST_DISPLAY)  row_d = '0;

    if (err_d)                                good_d = '0;
    else if (good_frame && good_q != GOOD_MAX) good_d = good_q + 1'b1;

    de_d     = (state_d == ST_DISPLAY);
    locked_d = (good_d == GOOD_MAX);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SEARCH;
      cnt_q    <= '0;
      row_q    <= '0;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      good_q   <= good_d;
    end
  end

  assign bus.row         = row_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.locked      = locked_q;
  assign bus.err         = err_q;
  assign bus.state       = state_q;

`ifdef VSYNC_DEC_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Saturating count of err pulses; lock has no effect on it.
  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end

  assign bus.err_count = errcnt_q;
`endif

endmodule
